feature_mem_buf: RTL and testbench
==================================

Name: feature_mem_buf

Overview:
Parametrised single-port data memory for the texture-feature datapath. It generalises the fixed 16x128 store to configurable width and depth. A sequential clear engine (one word per cycle, with a busy flag) replaces the all-at-once array reset. The block also adds a read-valid strobe, a write-acknowledge pulse and out-of-range address detection. It sits between the feature-extraction FSM and the result readout logic.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 8, address bus width in bits
DEPTH, 128, number of words; legal range 2..2^ADDR_W

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; starts a clear sweep
en  in  1  access request, sampled each edge
r_w  in  1  1 = read, 0 = write
abus  in  ADDR_W  word address
dbus_in  in  DATA_W  write data
clr  in  1  single-cycle pulse; starts a clear sweep without asserting reset
dbus_out  out  DATA_W  read data, or write-through data on write
rd_valid  out  1  one-cycle pulse: dbus_out holds read data
stored  out  1  one-cycle pulse: write committed
addr_err  out  1  one-cycle pulse: request had abus >= DEPTH
busy  out  1  clear sweep in progress; requests ignored

Behaviour:
- Reset is synchronous and active-high on clk; there is no asynchronous path.
- Reset values, at the edge where reset=1:
  - dbus_out=0, rd_valid=0, stored=0, addr_err=0.
  - busy=1 and clear counter=0.
- State machine states: SWEEP and IDLE.
  - Reset enters SWEEP; clr=1 while in IDLE also enters SWEEP.
- SWEEP:
  - Each cycle, write 0 to m[cnt] and increment cnt.
  - When cnt==DEPTH-1 is written, return to IDLE and deassert busy on the same edge.
  - busy is high for exactly DEPTH cycles after reset is released.
  - en requests are dropped silently: no pulses, dbus_out holds its value.
  - clr during SWEEP is ignored.
- Reset asserted mid-sweep restarts the counter at 0.
- IDLE write (en=1, r_w=0, abus<DEPTH):
  - m[abus]<=dbus_in.
  - dbus_out<=dbus_in.
  - stored=1 for one cycle at the following edge.
- IDLE read (en=1, r_w=1, abus<DEPTH):
  - dbus_out<=m[abus] and rd_valid=1, both one edge after the request (latency 1).
- Read of an address written in the previous cycle returns the new data; there are no stale reads.
- Back-to-back requests are accepted every cycle, so throughput is 1 access per cycle.
- Out of range (en=1, abus>=DEPTH):
  - No memory access.
  - addr_err=1 for one cycle; stored=0 and rd_valid=0.
  - dbus_out is held.
- Idle (en=0): all pulses 0, dbus_out held. The bus is never tri-stated.
- clr and en asserted in the same IDLE cycle: clr wins, the request is dropped, and busy rises on the next edge.
- Pulses are never high simultaneously.
- The counter is ADDR_W+1 bits wide so that DEPTH=2^ADDR_W does not wrap early.

Decomposition:
- Shared package feature_mem_pkg holds:
  - The state encoding (ST_IDLE=1'b0, ST_SWEEP=1'b1).
  - The r_w encodings (OP_WRITE=0, OP_READ=1).
- One sub-module, mem_clear_ctrl, holds the sweep counter, busy flag and state register.
  - It outputs clear_we, clear_addr and busy.
- The top level muxes the array write port between clear_ctrl and the user path.

Test Plan:
- Reset for 1 cycle, DEPTH=128:
  - busy is high for exactly 128 cycles.
  - Afterwards, reads of addresses 0, 64 and 127 return 0 with rd_valid.
- Write 16'hA5A5 to 8'h10, then read 8'h10 on the next cycle:
  - stored pulses once.
  - Next edge: rd_valid=1 and dbus_out=16'hA5A5.
- Read at abus=8'd200 with DEPTH=128:
  - addr_err=1 for one cycle, rd_valid=0, dbus_out unchanged.
- Write 16'h1234 to address 5, then pulse clr together with a read of 5:
  - The read is dropped and busy is high for 128 cycles.
  - Afterwards a read of 5 returns 0.
- Assert reset mid-sweep at cnt=50:
  - Counter restarts and busy stays high a further 128 cycles after reset releases.
  - No pulses occur during the sweep.
- Streaming with DATA_W=32, DEPTH=256:
  - 256 consecutive writes, then 256 consecutive reads.
  - Each read matches the written data, with rd_valid high continuously for 256 cycles.

Source files
------------

// File: rtl/feature_mem_pkg.sv
// Shared encodings for the feature memory buffer and its clear controller.
package feature_mem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    // Index width for a DEPTH-word array; a 1-word index is the floor.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// Sequential clear engine: zeroes one word per cycle after reset or a clr
// pulse, and reports busy for exactly DEPTH cycles.
module mem_clear_ctrl
    import feature_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    output logic             busy_o,
    output logic             clear_we_o,
    output logic [IDX_W-1:0] clear_addr_o
);

    // One bit wider than the address so DEPTH == 2**ADDR_W cannot wrap early.
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

    state_e          state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first so no path through the case leaves a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o       = (state_q == ST_SWEEP);
    assign clear_we_o   = (state_q == ST_SWEEP);
    assign clear_addr_o = cnt_q[IDX_W-1:0];

endmodule

// File: rtl/feature_mem_buf.sv
// Single-port feature data memory with registered read, write-through,
// access strobes, out-of-range detection and a sequential clear sweep.
module feature_mem_buf
    import feature_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              r_w,
    input  logic [ADDR_W-1:0] abus,
    input  logic [DATA_W-1:0] dbus_in,
    input  logic              clr,
    output logic [DATA_W-1:0] dbus_out,
    output logic              rd_valid,
    output logic              stored,
    output logic              addr_err,
    output logic              busy
);

    localparam int              IDX_W   = idx_w(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rd_valid_q, stored_q, addr_err_q;

    logic              clear_we;
    logic [IDX_W-1:0]  clear_addr;
    logic [IDX_W-1:0]  idx;
    logic              in_range, accept, user_we, user_re, oor;

    mem_clear_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_clear_ctrl (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (clr),
        .busy_o       (busy),
        .clear_we_o   (clear_we),
        .clear_addr_o (clear_addr)
    );

    // A clr in the same cycle as a request takes priority and drops it.
    assign in_range = ({1'b0, abus} < DEPTH_C);
    assign accept   = en & ~busy & ~clr & ~reset;
    assign user_we  = accept & in_range & (r_w == OP_WRITE);
    assign user_re  = accept & in_range & (r_w == OP_READ);
    assign oor      = accept & ~in_range;
    assign idx      = abus[IDX_W-1:0];

    // NOTE: the array has no reset branch; the clear sweep zeroes it one
    // word per cycle so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem_q[clear_addr] <= '0;
        end else if (user_we) begin
            mem_q[idx] <= dbus_in;
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (user_re) begin
            dout_d = mem_q[idx];
        end else if (user_we) begin
            dout_d = dbus_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            stored_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            rd_valid_q <= user_re;
            stored_q   <= user_we;
            addr_err_q <= oor;
        end
    end

    assign dbus_out = dout_q;
    assign rd_valid = rd_valid_q;
    assign stored   = stored_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_feature_mem_buf.sv
// Directed bench for feature_mem_buf: a 16x128 instance for the functional
// cases and a 32x256 instance for streaming, checked against a scoreboard.
module tb_feature_mem_buf;

    logic        clk = 1'b0;
    logic        reset, en, r_w, clr, sel;
    logic [7:0]  abus;
    logic [31:0] din;

    logic [15:0] dout_a;
    logic        rdv_a, st_a, ae_a, busy_a;
    logic [31:0] dout_b;
    logic        rdv_b, st_b, ae_b, busy_b;

    logic [31:0] o_dout;
    logic        o_rdv, o_st, o_ae, o_busy;

    always #5 clk = ~clk;

    feature_mem_buf #(.DATA_W(16), .ADDR_W(8), .DEPTH(128)) u_a (
        .clk      (clk),
        .reset    (reset),
        .en       (en & ~sel),
        .r_w      (r_w),
        .abus     (abus),
        .dbus_in  (din[15:0]),
        .clr      (clr & ~sel),
        .dbus_out (dout_a),
        .rd_valid (rdv_a),
        .stored   (st_a),
        .addr_err (ae_a),
        .busy     (busy_a)
    );

    feature_mem_buf #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) u_b (
        .clk      (clk),
        .reset    (reset),
        .en       (en & sel),
        .r_w      (r_w),
        .abus     (abus),
        .dbus_in  (din),
        .clr      (clr & sel),
        .dbus_out (dout_b),
        .rd_valid (rdv_b),
        .stored   (st_b),
        .addr_err (ae_b),
        .busy     (busy_b)
    );

    always_comb begin
        o_dout = sel ? dout_b : {16'h0000, dout_a};
        o_rdv  = sel ? rdv_b  : rdv_a;
        o_st   = sel ? st_b   : st_a;
        o_ae   = sel ? ae_b   : ae_a;
        o_busy = sel ? busy_b : busy_a;
    end

    typedef struct {
        logic [31:0] dout;
        logic        rdv;
        logic        st;
        logic        ae;
        logic        busy;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mmem [2][256];
    logic [31:0] mhold [2];
    int          total = 0;
    int          bad   = 0;

    function automatic int cur();
        return sel ? 1 : 0;
    endfunction

    function automatic int depth_of();
        return sel ? 256 : 128;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_next();
        exp_t x;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            x = sb.pop_front();
            cmp({x.tag, "_dout"},  o_dout,        x.dout);
            cmp({x.tag, "_rdv"},   32'(o_rdv),    32'(x.rdv));
            cmp({x.tag, "_st"},    32'(o_st),     32'(x.st));
            cmp({x.tag, "_ae"},    32'(o_ae),     32'(x.ae));
            cmp({x.tag, "_busy"},  32'(o_busy),   32'(x.busy));
        end
    endtask

    task automatic clear_model(input int s);
        for (int i = 0; i < 256; i++) mmem[s][i] = 32'h0;
    endtask

    // One idle-state request: predict, push, clock, pop and compare.
    task automatic access(input logic e, input logic rw, input logic [7:0] a,
                          input logic [31:0] d, input logic c, input string tag);
        exp_t        x;
        int          s;
        logic [31:0] mask;
        s    = cur();
        mask = sel ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        en = e; r_w = rw; abus = a; din = d; clr = c;
        x.dout = mhold[s]; x.rdv = 1'b0; x.st = 1'b0; x.ae = 1'b0; x.busy = 1'b0;
        x.tag  = tag;
        if (c) begin
            x.busy = 1'b1;
            clear_model(s);
        end else if (e) begin
            if (int'(a) >= depth_of()) begin
                x.ae = 1'b1;
            end else if (rw) begin
                x.rdv  = 1'b1;
                x.dout = mmem[s][a];
            end else begin
                x.st        = 1'b1;
                x.dout      = d & mask;
                mmem[s][a]  = d & mask;
            end
        end
        mhold[s] = x.dout;
        sb.push_back(x);
        @(posedge clk); #1;
        en = 1'b0; clr = 1'b0;
        check_next();
    endtask

    task automatic do_reset(input string tag);
        exp_t x;
        reset = 1'b1; en = 1'b0; clr = 1'b0;
        mhold[0] = 32'h0; mhold[1] = 32'h0;
        clear_model(0); clear_model(1);
        x.dout = 32'h0; x.rdv = 1'b0; x.st = 1'b0; x.ae = 1'b0; x.busy = 1'b1;
        x.tag  = tag;
        sb.push_back(x);
        @(posedge clk); #1;
        reset = 1'b0;
        check_next();
    endtask

    // Random traffic while sweeping must be dropped without side effects.
    task automatic sweep_edge(input string tag);
        en = 1'b1; r_w = 1'($urandom); abus = 8'($urandom); din = $urandom;
        clr = ($urandom_range(3) == 0);
        @(posedge clk); #1;
        cmp({tag, "_pulses"}, {29'h0, o_rdv, o_st, o_ae}, 32'h0);
        cmp({tag, "_hold"},   o_dout, mhold[cur()]);
    endtask

    task automatic sweep_run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            sweep_edge(tag);
            cmp({tag, "_busy"}, 32'(o_busy), 32'h1);
        end
        en = 1'b0; clr = 1'b0;
    endtask

    task automatic sweep_wait(input int expect_n, input string tag);
        int n;
        n = 0;
        while (o_busy && n < 1000) begin
            sweep_edge(tag);
            n++;
        end
        en = 1'b0; clr = 1'b0;
        cmp({tag, "_busy_len"}, 32'(n), 32'(expect_n));
    endtask

    initial begin
        int rd_run;
        sel = 1'b0; reset = 1'b0; en = 1'b0; r_w = 1'b0; clr = 1'b0;
        abus = 8'h00; din = 32'h0;
        mhold[0] = 32'h0; mhold[1] = 32'h0;
        clear_model(0); clear_model(1);

        do_reset("rst");
        sweep_wait(128, "init_sweep");

        access(1'b1, 1'b1, 8'd0,   32'h0, 1'b0, "rd0");
        access(1'b1, 1'b1, 8'd64,  32'h0, 1'b0, "rd64");
        access(1'b1, 1'b1, 8'd127, 32'h0, 1'b0, "rd127");

        access(1'b1, 1'b0, 8'h10,  32'h0000_A5A5, 1'b0, "wr10");
        access(1'b1, 1'b1, 8'h10,  32'h0,         1'b0, "rd10");

        access(1'b1, 1'b1, 8'd200, 32'h0,         1'b0, "oor_rd200");
        access(1'b1, 1'b1, 8'd128, 32'h0,         1'b0, "oor_rd128");
        access(1'b1, 1'b0, 8'd255, 32'h0000_FFFF, 1'b0, "oor_wr255");
        access(1'b0, 1'b1, 8'h10,  32'h0,         1'b0, "idle");
        access(1'b1, 1'b1, 8'h10,  32'h0,         1'b0, "rd10_again");

        access(1'b1, 1'b0, 8'd5,   32'h0000_1234, 1'b0, "wr5");
        access(1'b1, 1'b1, 8'd5,   32'h0,         1'b1, "clr_rd5");
        sweep_wait(128, "clr_sweep");
        access(1'b1, 1'b1, 8'd5,   32'h0,         1'b0, "rd5_cleared");
        access(1'b1, 1'b1, 8'h10,  32'h0,         1'b0, "rd10_cleared");

        do_reset("rst_a");
        sweep_run(50, "pre_mid");
        do_reset("rst_mid");
        sweep_wait(128, "mid_sweep");
        access(1'b1, 1'b1, 8'd50,  32'h0, 1'b0, "rd50_post_mid");

        sel = 1'b1;
        do_reset("rst_b");
        sweep_wait(256, "b_sweep");
        for (int i = 0; i < 256; i++) begin
            access(1'b1, 1'b0, 8'(i), $urandom, 1'b0, "stream_wr");
        end
        rd_run = 0;
        for (int i = 0; i < 256; i++) begin
            access(1'b1, 1'b1, 8'(i), 32'h0, 1'b0, "stream_rd");
            if (o_rdv) rd_run++;
        end
        cmp("stream_rdv_run", 32'(rd_run), 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
